// File: rtl/rx_sd_pkg.sv
// Shared types and constants for the RX sphere-decoder real-sample buffer path.
package rx_sd_pkg;

   localparam int BUF_DEPTH = 14;
   localparam int BUF_AW    = 4;
   localparam int SAMPLE_W  = 16;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } rd_state_t;

endpackage

// File: rtl/ram_real_reader_if.sv
// Bundles the buffer read port and the downstream sample stream of the reader.
// The master side is the reader; the slave side is the buffer plus the consumer.
interface ram_real_reader_if #(
   parameter int AW = rx_sd_pkg::BUF_AW,
   parameter int DW = rx_sd_pkg::SAMPLE_W
) ();

   logic                 ram_en;
   logic                 ram_we;
   logic [AW-1:0]        ram_addr;
   logic signed [DW-1:0] ram_dout;

   logic                 m_valid;
   logic signed [DW-1:0] m_data;
   logic                 m_last;
   logic                 m_ready;

   modport master (
      output ram_en,
      output ram_we,
      output ram_addr,
      input  ram_dout,
      output m_valid,
      output m_data,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  ram_en,
      input  ram_we,
      input  ram_addr,
      output ram_dout,
      input  m_valid,
      input  m_data,
      input  m_last,
      output m_ready
   );

endinterface

// File: rtl/sample_skid_fifo.sv
// Two-entry flow-through skid FIFO holding {last, sample} pairs.
// An arriving word is visible at the head in the same cycle when the FIFO is
// empty, so a sample returned by the buffer can be handed off without an extra
// register stage; if it is not accepted it is stored and held stable.
module sample_skid_fifo
   import rx_sd_pkg::*;
#(
   parameter int DW = SAMPLE_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic signed [DW-1:0] push_data,
   input  logic                 push_last,
   input  logic                 pop,
   output logic                 valid,
   output logic signed [DW-1:0] head_data,
   output logic                 head_last,
   output logic [1:0]           count
);

   logic signed [DW-1:0] mem_data [2];
   logic                 mem_last [2];
   logic                 wr_sel;
   logic                 rd_sel;
   logic                 empty;
   logic                 do_write;
   logic                 do_read;

   assign empty     = (count == 2'd0);
   assign valid     = !empty || push;
   assign head_data = !empty ? mem_data[rd_sel] : (push ? push_data : '0);
   assign head_last = !empty ? mem_last[rd_sel] : (push && push_last);

   // A word pushed into an empty FIFO and popped in the same cycle passes straight through.
   assign do_read  = pop && !empty;
   assign do_write = push && !(empty && pop);

   // Storage and pointer update; when full, a simultaneous pop frees the slot being written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            mem_data[i] <= '0;
            mem_last[i] <= 1'b0;
         end
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_write) begin
            mem_data[wr_sel] <= push_data;
            mem_last[wr_sel] <= push_last;
            wr_sel           <= ~wr_sel;
         end
         if (do_read) begin
            rd_sel <= ~rd_sel;
         end
         count <= count + {1'b0, do_write} - {1'b0, do_read};
      end
   end

endmodule

// File: rtl/ram_real_reader.sv
// Read-side sequencer for the real-sample buffer: on start it reads frame_len
// samples from address 0 through the 1-cycle-latency buffer port and streams
// them out on a valid/ready interface with a last flag and a done pulse.
module ram_real_reader
   import rx_sd_pkg::*;
#(
   parameter int DEPTH = BUF_DEPTH,
   parameter int AW    = BUF_AW,
   parameter int DW    = SAMPLE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [AW-1:0]     frame_len,
   output logic              busy,
   output logic              done,
   ram_real_reader_if.master bus
);

   localparam logic [AW-1:0] DEPTH_L = AW'(DEPTH);

   rd_state_t            state;
   logic [AW-1:0]        len;
   logic [AW-1:0]        rd_ptr;
   logic [AW-1:0]        req_len;
   logic [AW-1:0]        last_addr;
   logic                 inflight;
   logic                 inflight_last;
   logic                 issue;
   logic                 handshake;
   logic                 fifo_valid;
   logic                 head_last;
   logic signed [DW-1:0] head_data;
   logic [1:0]           fifo_count;
   logic [2:0]           credit;

   assign req_len   = (frame_len > DEPTH_L) ? DEPTH_L : frame_len;
   assign last_addr = len - AW'(1);

   // Reads are only issued while the FIFO plus the read in flight leave a free slot.
   assign credit = {1'b0, fifo_count} + {2'b00, inflight};
   assign issue  = (state == READ) && (rd_ptr < len) && (credit < 3'd2);

   assign bus.ram_en   = issue;
   assign bus.ram_we   = 1'b0;
   assign bus.ram_addr = issue ? rd_ptr : '0;

   assign handshake   = fifo_valid && bus.m_ready;
   assign bus.m_valid = fifo_valid;
   assign bus.m_data  = head_data;
   assign bus.m_last  = head_last;

   // Sequencer FSM with registered busy/done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         len    <= '0;
         rd_ptr <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  len    <= req_len;
                  rd_ptr <= '0;
                  busy   <= 1'b1;
                  state  <= (req_len == '0) ? DONE : READ;
               end
            end
            READ: begin
               if (issue) begin
                  rd_ptr <= rd_ptr + AW'(1);
                  if (rd_ptr == last_addr) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (handshake && head_last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               // An empty frame arrives here with done still low and spends one cycle raising it.
               if (done) begin
                  done  <= 1'b0;
                  state <= IDLE;
               end else begin
                  done <= 1'b1;
                  busy <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Track the read in flight so its data is captured the cycle after ram_en, tagged if last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= issue;
         inflight_last <= issue && (rd_ptr == last_addr);
      end
   end

   sample_skid_fifo #(
      .DW(DW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data (bus.ram_dout),
      .push_last (inflight_last),
      .pop       (handshake),
      .valid     (fifo_valid),
      .head_data (head_data),
      .head_last (head_last),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_ram_real_reader.sv
// Directed bench for ram_real_reader with a behavioural 1-cycle-latency buffer.
module tb_ram_real_reader;
   import rx_sd_pkg::*;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] frame_len;
   logic       busy;
   logic       done;

   sample_t    ram_mem [16];
   int         checks;
   int         passed;

   ram_real_reader_if bus ();

   ram_real_reader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .frame_len (frame_len),
      .busy      (busy),
      .done      (done),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Buffer model: registered read, data valid the cycle after ram_en.
   always @(posedge clk) begin
      if (bus.ram_en) bus.ram_dout <= ram_mem[bus.ram_addr];
   end

   task automatic preload();
      for (int a = 0; a < 16; a++) ram_mem[a] = (a < 14) ? sample_t'(100 + a) : sample_t'(999);
   endtask

   // Pulses start for one cycle, returns sampling inside cycle E0+1.
   task automatic start_frame(input logic [3:0] len);
      @(negedge clk);
      start     = 1'b1;
      frame_len = len;
      @(negedge clk);
      start = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      logic [25:0] got;
      rst = 1'b1;
      start = 1'b0;
      frame_len = 4'd0;
      bus.m_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      got = {busy, done, bus.m_valid, bus.m_last, bus.ram_en, bus.ram_we, bus.ram_addr, bus.m_data};
      checks++;
      if (got !== 26'd0) $display("[TB] FAIL reset_state: got %h expected %h", got, 26'd0);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // 14-sample frame with ready high; also pulses start while in DONE.
   task automatic test_full_frame();
      logic [25:0] got;
      logic [25:0] exp;
      logic        e_valid;
      logic        e_en;
      sample_t     e_data;
      logic [3:0]  e_addr;
      bus.m_ready = 1'b1;
      start_frame(4'd14);
      for (int cyc = 1; cyc <= 18; cyc++) begin
         if (cyc > 1) begin
            @(negedge clk);
            start = (cyc == 16);
            #1;
         end
         e_valid = (cyc >= 2) && (cyc <= 15);
         e_data  = e_valid ? sample_t'(100 + cyc - 2) : sample_t'(0);
         e_en    = (cyc <= 14);
         e_addr  = e_en ? 4'(cyc - 1) : 4'd0;
         exp = {(cyc <= 15), (cyc == 16), e_valid, (cyc == 15), e_en, 1'b0, e_addr, e_data};
         got = {busy, done, bus.m_valid, bus.m_last, bus.ram_en, bus.ram_we, bus.ram_addr, bus.m_data};
         checks++;
         if (got !== exp) $display("[TB] FAIL full_frame cyc%0d {busy,done,valid,last,en,we,addr,data}: got %h expected %h", cyc, got, exp);
         else passed++;
      end
      start = 1'b0;
   endtask

   // Short frame under a stalling consumer; checks order, hold-while-stalled, addresses, last.
   task automatic test_backpressure();
      int      pat [6] = '{1, 0, 0, 1, 0, 1};
      int      n_hs;
      int      max_addr;
      int      n_done;
      logic    prev_stall;
      sample_t prev_data;
      logic    prev_last;
      n_hs = 0; max_addr = 0; n_done = 0; prev_stall = 1'b0;
      prev_data = '0; prev_last = 1'b0;
      bus.m_ready = 1'b1;
      start_frame(4'd5);
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (cyc > 1) begin
            @(negedge clk);
            bus.m_ready = pat[(cyc - 1) % 6][0];
            #1;
         end
         if (prev_stall) begin
            checks++;
            if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, prev_data, prev_last})
               $display("[TB] FAIL stall_hold cyc%0d: got valid=%b data=%0d last=%b expected valid=1 data=%0d last=%b",
                        cyc, bus.m_valid, bus.m_data, bus.m_last, prev_data, prev_last);
            else passed++;
         end
         if (bus.ram_en && (int'(bus.ram_addr) > max_addr)) max_addr = int'(bus.ram_addr);
         if (bus.m_valid && bus.m_ready) begin
            checks++;
            if ({bus.m_data, bus.m_last} !== {sample_t'(100 + n_hs), (n_hs == 4)})
               $display("[TB] FAIL bp_sample%0d: got data=%0d last=%b expected data=%0d last=%b",
                        n_hs, bus.m_data, bus.m_last, 100 + n_hs, (n_hs == 4));
            else passed++;
            n_hs++;
         end
         if (done) n_done++;
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_data  = bus.m_data;
         prev_last  = bus.m_last;
      end
      checks++;
      if ({n_hs, max_addr, n_done} !== {32'd5, 32'd4, 32'd1})
         $display("[TB] FAIL bp_totals: got hs=%0d max_addr=%0d done=%0d expected hs=5 max_addr=4 done=1", n_hs, max_addr, n_done);
      else passed++;
      bus.m_ready = 1'b1;
   endtask

   task automatic test_zero_len();
      logic [3:0] got;
      logic [3:0] exp;
      bus.m_ready = 1'b1;
      start_frame(4'd0);
      for (int cyc = 1; cyc <= 4; cyc++) begin
         if (cyc > 1) begin
            @(negedge clk);
            #1;
         end
         exp = {(cyc == 1), (cyc == 2), 1'b0, 1'b0};
         got = {busy, done, bus.ram_en, bus.m_valid};
         checks++;
         if (got !== exp) $display("[TB] FAIL zero_len cyc%0d {busy,done,en,valid}: got %b expected %b", cyc, got, exp);
         else passed++;
      end
   endtask

   task automatic test_clamp();
      int n_hs;
      int max_addr;
      int done_cyc;
      n_hs = 0; max_addr = 0; done_cyc = -1;
      bus.m_ready = 1'b1;
      start_frame(4'd15);
      for (int cyc = 1; cyc <= 20; cyc++) begin
         if (cyc > 1) begin
            @(negedge clk);
            #1;
         end
         if (bus.ram_en && (int'(bus.ram_addr) > max_addr)) max_addr = int'(bus.ram_addr);
         if (bus.m_valid && bus.m_ready) begin
            checks++;
            if ({bus.m_data, bus.m_last} !== {sample_t'(100 + n_hs), (n_hs == 13)})
               $display("[TB] FAIL clamp_sample%0d: got data=%0d last=%b expected data=%0d last=%b",
                        n_hs, bus.m_data, bus.m_last, 100 + n_hs, (n_hs == 13));
            else passed++;
            n_hs++;
         end
         if (done && (done_cyc < 0)) done_cyc = cyc;
      end
      checks++;
      if ({n_hs, max_addr, done_cyc} !== {32'd14, 32'd13, 32'd16})
         $display("[TB] FAIL clamp_totals: got hs=%0d max_addr=%0d done_cyc=%0d expected hs=14 max_addr=13 done_cyc=16",
                  n_hs, max_addr, done_cyc);
      else passed++;
   endtask

   task automatic test_negative();
      logic [18:0] got;
      logic [18:0] exp;
      ram_mem[0] = 16'sh8000;
      ram_mem[1] = 16'shFFFF;
      bus.m_ready = 1'b1;
      start_frame(4'd2);
      for (int cyc = 1; cyc <= 5; cyc++) begin
         if (cyc > 1) begin
            @(negedge clk);
            #1;
         end
         case (cyc)
            2:       exp = {1'b1, 16'sh8000, 1'b0, 1'b0};
            3:       exp = {1'b1, 16'shFFFF, 1'b1, 1'b0};
            4:       exp = {1'b0, 16'sh0000, 1'b0, 1'b1};
            default: exp = {1'b0, 16'sh0000, 1'b0, 1'b0};
         endcase
         got = {bus.m_valid, bus.m_data, bus.m_last, done};
         checks++;
         if (got !== exp) $display("[TB] FAIL negative cyc%0d {valid,data,last,done}: got %h expected %h", cyc, got, exp);
         else passed++;
      end
      preload();
   endtask

   // Start during busy is ignored, reset after the third handshake aborts, then a clean frame.
   task automatic test_reset_mid_frame();
      logic [22:0] got;
      logic [22:0] exp;
      logic [25:0] all_out;
      logic        e_valid;
      bus.m_ready = 1'b1;
      start_frame(4'd14);
      for (int cyc = 1; cyc <= 4; cyc++) begin
         if (cyc > 1) begin
            @(negedge clk);
            start     = (cyc == 2);
            frame_len = 4'd3;
            #1;
         end
         e_valid = (cyc >= 2);
         exp = {e_valid, (e_valid ? sample_t'(100 + cyc - 2) : sample_t'(0)), 1'b1, 4'(cyc - 1), 1'b1};
         got = {bus.m_valid, bus.m_data, bus.ram_en, bus.ram_addr, busy};
         checks++;
         if (got !== exp) $display("[TB] FAIL busy_start cyc%0d {valid,data,en,addr,busy}: got %h expected %h", cyc, got, exp);
         else passed++;
      end
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b1;
      #1;
      all_out = {busy, done, bus.m_valid, bus.m_last, bus.ram_en, bus.ram_we, bus.ram_addr, bus.m_data};
      checks++;
      if (all_out !== 26'd0) $display("[TB] FAIL mid_reset_outputs: got %h expected %h", all_out, 26'd0);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         if (cyc > 0) @(negedge clk);
         #1;
         checks++;
         if ({busy, done, bus.m_valid, bus.ram_en} !== 4'b0000)
            $display("[TB] FAIL post_reset_idle cyc%0d {busy,done,valid,en}: got %b expected 0000",
                     cyc, {busy, done, bus.m_valid, bus.ram_en});
         else passed++;
      end
      test_full_frame();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks = 0;
      passed = 0;
      preload();
      test_reset();
      test_full_frame();
      test_backpressure();
      test_zero_len();
      test_clamp();
      test_negative();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/ram_real_reader.md
Name: ram_real_reader

Overview:
- Read-side sequencer for the 14-entry real-sample buffer in the RX sphere-decoder path.
- On a start pulse it reads frame_len consecutive samples from address 0 through the buffer's single enable/write-enable port, which has a 1-cycle read latency.
- It streams the samples downstream on a valid/ready interface, with full backpressure support and a last-sample flag.

Parameters:
- DEPTH, 14, number of buffer entries.
- AW, 4, address width; must satisfy 2^AW >= DEPTH.
- DW, 16, sample width, signed two's complement.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to read a frame; sampled only in IDLE.
- frame_len  in  AW  number of samples to read; latched when start is accepted.
- ram_en  out  1  buffer port enable.
- ram_we  out  1  buffer write enable; always 0.
- ram_addr  out  AW  buffer read address.
- ram_dout  in  DW signed  buffer read data; valid the cycle after ram_en=1.
- m_valid  out  1  output sample valid.
- m_data  out  DW signed  output sample.
- m_last  out  1  marks the final sample of the frame; qualified by m_valid.
- m_ready  in  1  downstream accept.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, skid FIFO flushed, counters cleared.
  - m_valid=0, m_data=0, m_last=0, busy=0, done=0, ram_en=0, ram_addr=0.
  - ram_we=0 at all times.
- Length handling when start is accepted:
  - frame_len > DEPTH is clamped to DEPTH.
  - frame_len=0: no reads are issued; state goes to DONE, and done pulses in the next cycle.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: start=1 latches len and clears rd_ptr and out_cnt; goes to READ (or DONE if len=0). busy=1 from the next cycle.
  - READ: issues a read when rd_ptr < len and (fifo_count + inflight) < 2. Issuing means ram_en=1 and ram_addr=rd_ptr (combinational from registered state), then rd_ptr increments. When the final read has been issued, goes to DRAIN.
  - DRAIN: no new reads. When the handshake of the sample tagged last completes, goes to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Read capture: the inflight flag is registered from ram_en. When inflight=1, ram_dout is pushed into the 2-entry skid FIFO together with a last tag, set when its address equals len-1.
- Output interface:
  - m_valid = FIFO not empty. m_data and m_last come from the FIFO head.
  - A handshake is m_valid & m_ready; it pops the head.
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable. No sample is dropped or duplicated.
  - The credit rule guarantees the FIFO never overflows.
- Latency and throughput:
  - Start accepted at edge E0: first ram_en in cycle E0+1, first m_valid in cycle E0+2.
  - With m_ready held high: 1 sample per cycle. For a frame of N, the last handshake is in cycle E0+N+1, and done is in cycle E0+N+2.
- Addressing: addresses issued are strictly 0..len-1 in order, never >= DEPTH, with no wrap.
- Start handling: start while busy or in DONE is ignored; there is no queuing.
- Reset mid-frame aborts immediately. No done pulse is emitted, and residual data is discarded.
- Arithmetic: data passes through unmodified; no sign extension or rounding.

Decomposition:
- Shared package rx_sd_pkg:
  - constants BUF_DEPTH=14, BUF_AW=4, SAMPLE_W=16.
  - typedef sample_t (signed [15:0]).
  - enum rd_state_t {IDLE, READ, DRAIN, DONE}.
- One sub-module: sample_skid_fifo.
  - 2 entries of {last, sample_t}, with push/pop/count.
  - Pop and push in the same cycle when full is legal (pop frees the slot first).

Test Plan:
- Preload buffer addresses 0..13 with 16'sd100+addr. Pulse start with frame_len=14 and m_ready=1.
  - Required: m_data = 100..113 on consecutive cycles from E0+2.
  - Required: m_last only with 113; done at E0+16; busy high for cycles E0+1..E0+15.
- frame_len=5, m_ready toggling 1,0,0,1,0,1...
  - Required: exactly the samples 100..104 in order, each held stable while stalled.
  - Required: ram_addr never exceeds 4; m_last only on 104.
- frame_len=0.
  - Required: no ram_en; m_valid stays 0; done at E0+2.
- frame_len=15 (out of range).
  - Required: clamped to 14 samples; no address above 13.
- Negative data: load 16'sh8000 at address 0 and 16'shFFFF at address 1; frame_len=2.
  - Required: m_data shows -32768 then -1, with no width or sign corruption.
- Assert rst for 1 cycle after the 3rd handshake of a 14-sample frame, and pulse start during busy.
  - Required: all outputs are 0 during reset, with no done pulse.
  - Required: the start pulsed during busy is ignored.
  - Required: a new start after reset yields 100..113 cleanly.
